vending_multi_fsm: RTL and testbench



---
 rtl/vending_pkg.sv | 31 +++
 rtl/vend_stock_bank.sv | 48 ++++
 rtl/vending_multi_fsm.sv | 163 ++++++++++++++++
 tb/tb_vending_multi_fsm.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared coin encodings, controller states and the coin-to-units helper for the
// multi-slot vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10,
    COIN_25   = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VEND,
    CHANGE
  } state_e;

  // Value of a coin code in 5-unit steps.
  function automatic logic [2:0] coin_value(input logic [1:0] coin);
    logic [2:0] units;
    case (coin)
      COIN_5:  units = 3'd1;
      COIN_10: units = 3'd2;
      COIN_25: units = 3'd5;
      default: units = 3'd0;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-slot 4-bit stock counters that saturate at zero, with a registered
// sold-out flag per slot.
module vend_stock_bank
  import vending_pkg::*;
#(
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned STOCK_INIT = 3,
  parameter int unsigned IdW        = 2
) (
  input  logic                 clk_sig,
  input  logic                 reset,
  input  logic                 dec_en,
  input  logic [IdW-1:0]       dec_idx,
  output logic [NUM_ITEMS-1:0] sold_out
);

  logic [3:0]           stock_q [NUM_ITEMS];
  logic [3:0]           stock_d [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] sold_out_q, sold_out_d;

  always_comb begin
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      stock_d[i] = stock_q[i];
      if (dec_en && dec_idx == IdW'(i) && stock_q[i] != 4'd0) begin
        stock_d[i] = stock_q[i] - 4'd1;
      end
      // Flag follows the post-decrement count so it is visible alongside the vend.
      sold_out_d[i] = (stock_d[i] == 4'd0);
    end
  end

  always_ff @(posedge clk_sig or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i] <= 4'(STOCK_INIT);
      end
      sold_out_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i] <= stock_d[i];
      end
      sold_out_q <= sold_out_d;
    end
  end

  assign sold_out = sold_out_q;

endmodule

// File: rtl/vending_multi_fsm.sv
// Multi-slot coin vending controller: credit collection, vend, serial change and refund.
// Optional AUTO_VEND_EN macro enables legacy auto-vend of slot 0 once credit covers the price.
module vending_multi_fsm
  import vending_pkg::*;
#(
  parameter int unsigned PRICE_UNITS = 4,
  parameter int unsigned NUM_ITEMS   = 4,
  parameter int unsigned STOCK_INIT  = 3,
  parameter int unsigned MAX_UNITS   = 12,
  localparam int unsigned IdW        = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1,
  localparam int unsigned CW         = $clog2(MAX_UNITS + 1)
) (
  input  logic                 clk_sig,
  input  logic                 reset,
  input  logic [1:0]           coin_in,
  input  logic                 select_valid,
  input  logic [IdW-1:0]       select_id,
  input  logic                 cancel,
  output logic                 item_out,
  output logic [IdW-1:0]       item_id,
  output logic                 return5,
  output logic                 coin_reject,
  output logic                 busy,
  output logic [CW-1:0]        credit,
  output logic [NUM_ITEMS-1:0] sold_out
);

  state_e         state_q, state_d;
  logic [CW-1:0]  credit_q, credit_d;
  logic [CW-1:0]  change_q, change_d;
  logic [IdW-1:0] item_id_q, item_id_d;
  logic           item_out_q, item_out_d;
  logic           return5_q, return5_d;
  logic           coin_reject_q, coin_reject_d;
  logic           busy_q, busy_d;

  logic [2:0]     coin_units;
  int unsigned    credit_ext;
  logic           coin_fits;
  logic           sel_ok;
  logic           vend_go;
  logic [IdW-1:0] vend_idx;

  assign coin_units = coin_value(coin_in);
  assign credit_ext = 32'(credit_q);
  assign coin_fits  = (credit_ext + 32'(coin_units)) <= MAX_UNITS;
  // Out-of-range ids are rejected before the sold-out lookup is trusted.
  assign sel_ok     = (credit_ext >= PRICE_UNITS) && (32'(select_id) < NUM_ITEMS) &&
                      !sold_out[select_id];

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    change_d      = change_q;
    item_id_d     = item_id_q;
    coin_reject_d = 1'b0;
    vend_go       = 1'b0;
    vend_idx      = select_id;
    unique case (state_q)
      IDLE: begin
        if (coin_in != COIN_NONE) begin
          if (coin_fits) begin
            credit_d = CW'(credit_ext + 32'(coin_units));
            state_d  = COLLECT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (cancel) begin
          state_d       = CHANGE;
          change_d      = credit_q;
          credit_d      = '0;
          coin_reject_d = (coin_in != COIN_NONE);
        end else if (select_valid) begin
          coin_reject_d = (coin_in != COIN_NONE);
          vend_go       = sel_ok;
`ifdef AUTO_VEND_EN
        end else if (credit_ext >= PRICE_UNITS && !sold_out[0]) begin
          coin_reject_d = (coin_in != COIN_NONE);
          vend_go       = 1'b1;
          vend_idx      = '0;
`endif
        end else if (coin_in != COIN_NONE) begin
          if (coin_fits) begin
            credit_d = CW'(credit_ext + 32'(coin_units));
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      VEND: begin
        coin_reject_d = (coin_in != COIN_NONE);
        state_d       = (change_q != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        coin_reject_d = (coin_in != COIN_NONE);
        // change_q counts the pulse being shown now, so leave on the last one.
        if (change_q <= CW'(1)) begin
          change_d = '0;
          state_d  = IDLE;
        end else begin
          change_d = change_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (vend_go) begin
      state_d   = VEND;
      item_id_d = vend_idx;
      change_d  = CW'(credit_ext - PRICE_UNITS);
      credit_d  = '0;
    end

    item_out_d = vend_go;
    return5_d  = (state_d == CHANGE);
    busy_d     = (state_d == VEND) || (state_d == CHANGE);
  end

  always_ff @(posedge clk_sig or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      change_q      <= '0;
      item_id_q     <= '0;
      item_out_q    <= 1'b0;
      return5_q     <= 1'b0;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      change_q      <= change_d;
      item_id_q     <= item_id_d;
      item_out_q    <= item_out_d;
      return5_q     <= return5_d;
      coin_reject_q <= coin_reject_d;
      busy_q        <= busy_d;
    end
  end

  vend_stock_bank #(
    .NUM_ITEMS (NUM_ITEMS),
    .STOCK_INIT(STOCK_INIT),
    .IdW       (IdW)
  ) u_stock_bank (
    .clk_sig (clk_sig),
    .reset   (reset),
    .dec_en  (vend_go),
    .dec_idx (vend_idx),
    .sold_out(sold_out)
  );

  assign item_out    = item_out_q;
  assign item_id     = item_id_q;
  assign return5     = return5_q;
  assign coin_reject = coin_reject_q;
  assign busy        = busy_q;
  assign credit      = credit_q;

endmodule

// File: tb/tb_vending_multi_fsm.sv
// Bench for vending_multi_fsm: directed scenarios plus random coins/selects/cancels,
// checked every cycle against a schedule-of-output-cycles reference model.
module tb_vending_multi_fsm;

  localparam int unsigned PRICE = 4;
  localparam int unsigned NI    = 4;
  localparam int unsigned SI    = 3;
  localparam int unsigned MAXU  = 12;
`ifdef AUTO_VEND_EN
  localparam bit AutoVend = 1'b1;
`else
  localparam bit AutoVend = 1'b0;
`endif

  logic          clk_sig = 1'b0;
  logic          reset;
  logic [1:0]    coin_in;
  logic          select_valid;
  logic [1:0]    select_id;
  logic          cancel;
  logic          item_out;
  logic [1:0]    item_id;
  logic          return5;
  logic          coin_reject;
  logic          busy;
  logic [3:0]    credit;
  logic [NI-1:0] sold_out;

  always #5 clk_sig = ~clk_sig;

  vending_multi_fsm #(
    .PRICE_UNITS(PRICE),
    .NUM_ITEMS  (NI),
    .STOCK_INIT (SI),
    .MAX_UNITS  (MAXU)
  ) dut (
    .clk_sig     (clk_sig),
    .reset       (reset),
    .coin_in     (coin_in),
    .select_valid(select_valid),
    .select_id   (select_id),
    .cancel      (cancel),
    .item_out    (item_out),
    .item_id     (item_id),
    .return5     (return5),
    .coin_reject (coin_reject),
    .busy        (busy),
    .credit      (credit),
    .sold_out    (sold_out)
  );

  // Reference model: each queued entry is one busy output cycle (vend pulse or refund coin).
  typedef struct {
    bit item;
  } slot_t;

  slot_t sched[$];
  int    m_credit;
  int    m_stock[NI];
  int    m_last_id;
  bit    m_rej;
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int units(input logic [1:0] c);
    if (c == 2'b01) return 1;
    if (c == 2'b10) return 2;
    if (c == 2'b11) return 5;
    return 0;
  endfunction

  task automatic model_reset();
    sched.delete();
    m_credit  = 0;
    m_last_id = 0;
    m_rej     = 1'b0;
    for (int i = 0; i < NI; i++) m_stock[i] = SI;
  endtask

  task automatic model_vend(input int id);
    slot_t e;
    m_stock[id]--;
    m_last_id = id;
    e.item = 1'b1;
    sched.push_back(e);
    e.item = 1'b0;
    for (int i = 0; i < m_credit - int'(PRICE); i++) sched.push_back(e);
    m_credit = 0;
  endtask

  task automatic model_edge();
    slot_t e;
    int    v;
    v     = units(coin_in);
    m_rej = 1'b0;
    if (sched.size() > 0) begin
      void'(sched.pop_front());
      m_rej = (v != 0);
    end else if (m_credit == 0) begin
      if (v != 0) begin
        if (v <= int'(MAXU)) m_credit = v;
        else m_rej = 1'b1;
      end
    end else if (cancel) begin
      m_rej  = (v != 0);
      e.item = 1'b0;
      for (int i = 0; i < m_credit; i++) sched.push_back(e);
      m_credit = 0;
    end else if (select_valid) begin
      m_rej = (v != 0);
      if (m_credit >= int'(PRICE) && int'(select_id) < int'(NI) && m_stock[select_id] > 0)
        model_vend(int'(select_id));
    end else if (AutoVend && m_credit >= int'(PRICE) && m_stock[0] > 0) begin
      m_rej = (v != 0);
      model_vend(0);
    end else if (v != 0) begin
      if (m_credit + v <= int'(MAXU)) m_credit += v;
      else m_rej = 1'b1;
    end
  endtask

  task automatic compare_all();
    logic [NI-1:0] so;
    for (int i = 0; i < NI; i++) so[i] = (m_stock[i] == 0);
    check("item_out", 32'(item_out), 32'(sched.size() > 0 && sched[0].item));
    check("item_id", 32'(item_id), 32'(m_last_id));
    check("return5", 32'(return5), 32'(sched.size() > 0 && !sched[0].item));
    check("busy", 32'(busy), 32'(sched.size() > 0));
    check("coin_reject", 32'(coin_reject), 32'(m_rej));
    check("credit", 32'(credit), 32'(m_credit));
    check("sold_out", 32'(sold_out), 32'(so));
  endtask

  task automatic cyc(input logic [1:0] c, input logic s, input logic [1:0] id, input logic k);
    coin_in      = c;
    select_valid = s;
    select_id    = id;
    cancel       = k;
    @(posedge clk_sig);
    model_edge();
    #1 compare_all();
  endtask

  // Asserts reset away from the clock edge and checks it takes effect before the next edge.
  task automatic pulse_reset();
    coin_in      = 2'b00;
    select_valid = 1'b0;
    cancel       = 1'b0;
    #1 reset = 1'b1;
    #1 model_reset();
    compare_all();
    @(posedge clk_sig);
    #1 reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'b00, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic buy(input logic [1:0] id);
    cyc(2'b10, 1'b0, 2'd0, 1'b0);
    cyc(2'b10, 1'b0, 2'd0, 1'b0);
    cyc(2'b00, 1'b1, id, 1'b0);
    idle(2);
  endtask

  initial begin
    reset        = 1'b1;
    coin_in      = 2'b00;
    select_valid = 1'b0;
    select_id    = 2'd0;
    cancel       = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_sig);
    #1 compare_all();
    reset = 1'b0;

    // Exact price, slot 2.
    cyc(2'b01, 1'b0, 2'd0, 1'b0);
    cyc(2'b01, 1'b0, 2'd0, 1'b0);
    cyc(2'b10, 1'b0, 2'd0, 1'b0);
    cyc(2'b00, 1'b1, 2'd2, 1'b0);
    idle(2);

    // 25 coin then slot 0: one change pulse.
    cyc(2'b11, 1'b0, 2'd0, 1'b0);
    cyc(2'b00, 1'b1, 2'd0, 1'b0);
    idle(3);

    // Fill to ceiling, overflow coin, cancel refund of 12.
    cyc(2'b11, 1'b0, 2'd0, 1'b0);
    cyc(2'b11, 1'b0, 2'd0, 1'b0);
    cyc(2'b10, 1'b0, 2'd0, 1'b0);
    cyc(2'b01, 1'b0, 2'd0, 1'b0);
    cyc(2'b00, 1'b0, 2'd0, 1'b1);
    idle(14);

    // Deplete slot 1, retry is ignored with credit kept, then slot 3 succeeds.
    buy(2'd1);
    buy(2'd1);
    buy(2'd1);
    cyc(2'b10, 1'b0, 2'd0, 1'b0);
    cyc(2'b10, 1'b0, 2'd0, 1'b0);
    cyc(2'b00, 1'b1, 2'd1, 1'b0);
    cyc(2'b00, 1'b1, 2'd3, 1'b0);
    idle(2);

    // Coins during refund, then reset in the middle of it.
    cyc(2'b11, 1'b0, 2'd0, 1'b0);
    cyc(2'b11, 1'b0, 2'd0, 1'b0);
    cyc(2'b00, 1'b0, 2'd0, 1'b1);
    cyc(2'b10, 1'b0, 2'd0, 1'b0);
    cyc(2'b10, 1'b0, 2'd0, 1'b0);
    idle(3);
    pulse_reset();
    idle(2);

    // No select after reaching the price: waits, or auto-vends slot 0 in legacy mode.
    cyc(2'b10, 1'b0, 2'd0, 1'b0);
    cyc(2'b10, 1'b0, 2'd0, 1'b0);
    idle(3);
    cyc(2'b00, 1'b0, 2'd0, 1'b1);
    idle(6);

    for (int n = 0; n < 4000; n++) begin
      logic [1:0] c;
      logic [1:0] id;
      logic       s;
      logic       k;
      c  = ($urandom_range(0, 9) < 4) ? 2'($urandom_range(1, 3)) : 2'b00;
      s  = ($urandom_range(0, 9) < 2);
      k  = ($urandom_range(0, 29) == 0);
      id = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 249) == 0) pulse_reset();
      else cyc(c, s, id, k);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
